// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: assembles LSB-first bits into WIDTH-bit words
// and queues completed words in a 2-entry FIFO with valid/ready output.
module sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_overrun
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   sr_reg;

    logic [WIDTH-1:0]   mem_reg [2];
    logic               rd_ptr_reg;
    logic               wr_ptr_reg;
    logic [1:0]         count_reg;
    logic               overrun_reg;

    logic [CNT_W-1:0]   cnt_eff;
    logic [WIDTH-1:0]   base_word;
    logic [WIDTH-1:0]   asm_word;
    logic               word_done;
    logic               fifo_full;
    logic               pop;
    logic               push_ok;
    logic               drop;

    // sync discards the partial word before the current bit is placed
    assign cnt_eff   = sync ? '0 : cnt_reg;
    assign base_word = sync ? '0 : sr_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_asm
            assign asm_word[gi] = (cnt_eff == CNT_W'(gi)) ? in_bit : base_word[gi];
        end
    endgenerate

    assign word_done = in_valid && (cnt_eff == CNT_W'(WIDTH - 1));
    assign fifo_full = (count_reg == 2'd2);
    assign pop       = out_valid && out_ready;
    assign push_ok   = word_done && (!fifo_full || pop);
    assign drop      = word_done && fifo_full && !pop;

    assign out_valid = (count_reg != 2'd0);
    assign out_data  = mem_reg[rd_ptr_reg];
    assign busy      = (state_reg == SHIFT);
    assign overrun   = overrun_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sr_reg    <= '0;
        end else if (in_valid) begin
            if (word_done) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
                sr_reg    <= '0;
            end else begin
                state_reg <= SHIFT;
                cnt_reg   <= cnt_eff + CNT_W'(1);
                sr_reg    <= asm_word;
            end
        end else if (sync) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sr_reg    <= '0;
        end
    end

    // Full with simultaneous pop: wr_ptr equals the slot being freed, so the write is safe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem_reg[i] <= '0;
            rd_ptr_reg  <= 1'b0;
            wr_ptr_reg  <= 1'b0;
            count_reg   <= 2'd0;
            overrun_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_reg[wr_ptr_reg] <= asm_word;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
            if (drop)
                overrun_reg <= 1'b1;
            else if (clr_overrun)
                overrun_reg <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: stimulus pushes expected words, a negedge monitor
// pops and compares on every handshake.
module tb_sipo_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       sync = 1'b0;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       overrun;
    logic       clr_overrun = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_q[$];

    sipo_rx #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
        .sync(sync), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .overrun(overrun),
        .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    // Monitor: a handshake seen mid-cycle pops on the coming edge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got %h expected none", out_data);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    fails++;
                    $display("FAIL pop_data: got %h expected %h", out_data, e);
                end else begin
                    $display("[TB] pop %h", out_data);
                end
            end
        end
    end

    task automatic send_bit(input logic b, input logic s = 1'b0, input logic c = 1'b0);
        in_bit = b; in_valid = 1'b1; sync = s; clr_overrun = c;
        @(posedge clk); #1;
        in_valid = 1'b0; sync = 1'b0; clr_overrun = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 0; i < 4; i++) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin idle(1); n++; end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
        end
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_out_valid", {3'b0, out_valid}, 4'h0);
        check("rst_out_data", out_data, 4'h0);
        check("rst_busy", {3'b0, busy}, 4'h0);
        check("rst_overrun", {3'b0, overrun}, 4'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        out_ready = 1'b1;

        // Reset mid-word
        send_bit(1'b1); send_bit(1'b0);
        check("mid_busy", {3'b0, busy}, 4'h1);
        rst_n = 1'b0; #3;
        check("midrst_busy", {3'b0, busy}, 4'h0);
        check("midrst_valid", {3'b0, out_valid}, 4'h0);
        check("midrst_overrun", {3'b0, overrun}, 4'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        exp_q.push_back(4'hB);
        send_word(4'hB);
        idle(2);

        // Basic LSB-first with latency checks
        exp_q.push_back(4'hB); exp_q.push_back(4'hA);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        check("lat_before", {3'b0, out_valid}, 4'h0);
        send_bit(1'b1);
        check("lat_word1", {3'b0, out_valid}, 4'h1);
        check("lat_data1", out_data, 4'hB);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        check("lat_mid", {3'b0, out_valid}, 4'h0);
        send_bit(1'b1);
        check("lat_word2", {3'b0, out_valid}, 4'h1);
        check("lat_data2", out_data, 4'hA);
        idle(2);

        // Gaps and sync
        send_bit(1'b1); send_bit(1'b0);
        idle(3);
        check("gap_busy", {3'b0, busy}, 4'h1);
        send_bit(1'b1, 1'b1);
        check("sync_busy", {3'b0, busy}, 4'h1);
        send_bit(1'b1); send_bit(1'b1);
        check("sync_no_word", {3'b0, out_valid}, 4'h0);
        exp_q.push_back(4'hF);
        send_bit(1'b1);
        check("sync_valid", {3'b0, out_valid}, 4'h1);
        idle(2);

        // Backpressure and overrun
        out_ready = 1'b0;
        exp_q.push_back(4'h1); exp_q.push_back(4'h2);
        send_word(4'h1);
        check("bp_valid", {3'b0, out_valid}, 4'h1);
        check("bp_head", out_data, 4'h1);
        send_word(4'h2);
        check("bp_ovr_before", {3'b0, overrun}, 4'h0);
        send_word(4'h3);
        check("bp_overrun", {3'b0, overrun}, 4'h1);
        check("bp_head_stable", out_data, 4'h1);
        drain();
        idle(1);
        check("bp_third_absent", {3'b0, out_valid}, 4'h0);
        check("bp_ovr_sticky", {3'b0, overrun}, 4'h1);
        clr_overrun = 1'b1; idle(1); clr_overrun = 1'b0;
        check("bp_ovr_clr", {3'b0, overrun}, 4'h0);

        // Push while full with simultaneous pop
        out_ready = 1'b0;
        exp_q.push_back(4'h1); exp_q.push_back(4'h2); exp_q.push_back(4'hC);
        send_word(4'h1); send_word(4'h2);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        out_ready = 1'b1;
        send_bit(1'b1);
        check("pp_no_overrun", {3'b0, overrun}, 4'h0);
        drain();
        idle(1);

        // Set beats clear
        out_ready = 1'b0;
        exp_q.push_back(4'h1); exp_q.push_back(4'h2);
        send_word(4'h1); send_word(4'h2);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        check("prio_set_wins", {3'b0, overrun}, 4'h1);
        clr_overrun = 1'b1; idle(1); clr_overrun = 1'b0;
        check("prio_clear", {3'b0, overrun}, 4'h0);
        drain();
        idle(2);
        check("final_empty", {3'b0, out_valid}, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
